// File: rtl/led_pattern_scheduler.sv
// ---------------------------------------------------------------------------
// led_pattern_scheduler
//
// Front-panel LED sequencer for a 5-LED bank. A debounced push-button cycles
// through five display modes. A programmable divider produces a step tick,
// and each tick advances the LED pattern of the active mode.
//
// Ports:
//   i_clk    system clock (single domain)
//   i_rst    synchronous, active-high reset
//   i_btn    debounced button level; a rising edge advances the mode
//   i_pause  level; while high, the divider and pattern stepping are frozen
//   o_led    registered LED drive, bit0 = LED1 ... bit4 = LED5
//   o_mode   registered mode code (CHASE=0 BOUNCE=1 BLINK=2 COUNT=3 OFF=4)
//   o_tick   one-cycle pulse, high in the cycle a stepped pattern first shows
//
// Handshake: none. i_btn and i_pause are plain levels sampled every cycle.
// o_mode is the state register of the mode FSM and doubles as its debug view.
// ---------------------------------------------------------------------------
module led_pattern_scheduler #(
   parameter int TICK_DIV = 6250000,
   parameter int CNT_W    = 23
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_btn,
   input  logic       i_pause,
   output logic [4:0] o_led,
   output logic [2:0] o_mode,
   output logic       o_tick
);

   typedef enum logic [2:0] {
      MODE_CHASE  = 3'd0,
      MODE_BOUNCE = 3'd1,
      MODE_BLINK  = 3'd2,
      MODE_COUNT  = 3'd3,
      MODE_OFF    = 3'd4
   } mode_e;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   mode_e            mode_q, mode_d;
   logic [4:0]       led_q, led_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dir_up_q, dir_up_d;
   logic             tick_q, tick_d;
   logic             btn_q, btn_d;

   logic             btn_rise;
   logic             mode_legal;
   mode_e            mode_next;
   logic [4:0]       init_led;
   logic [4:0]       step_led;
   logic             step_dir_up;

   assign btn_rise = i_btn & ~btn_q;

   // Mode order and the legality check for the unused codes 5..7.
   always_comb begin
      mode_next  = MODE_CHASE;
      mode_legal = 1'b1;
      case (mode_q)
         MODE_CHASE:  mode_next = MODE_BOUNCE;
         MODE_BOUNCE: mode_next = MODE_BLINK;
         MODE_BLINK:  mode_next = MODE_COUNT;
         MODE_COUNT:  mode_next = MODE_OFF;
         MODE_OFF:    mode_next = MODE_CHASE;
         default: begin
            mode_next  = MODE_CHASE;
            mode_legal = 1'b0;
         end
      endcase
   end

   // Only CHASE and BOUNCE start with a lit LED.
   assign init_led = ((mode_next == MODE_CHASE) || (mode_next == MODE_BOUNCE))
                     ? 5'b00001 : 5'b00000;

   // Pattern step for the current mode, applied only on a tick.
   always_comb begin
      step_led    = led_q;
      step_dir_up = dir_up_q;
      case (mode_q)
         MODE_CHASE:  step_led = {led_q[3:0], led_q[4]};
         MODE_BOUNCE: begin
            // Direction flips on the step that lands on an end LED, so the
            // end LED is shown once and the next step moves back inward.
            if (dir_up_q) begin
               step_led = {led_q[3:0], 1'b0};
               if (step_led == 5'b10000) step_dir_up = 1'b0;
            end else begin
               step_led = {1'b0, led_q[4:1]};
               if (step_led == 5'b00001) step_dir_up = 1'b1;
            end
         end
         MODE_BLINK:  step_led = ~led_q;
         MODE_COUNT:  step_led = led_q + 5'd1;
         MODE_OFF:    step_led = 5'b00000;
         default:     step_led = led_q;
      endcase
   end

   // Next-state logic. Priority: illegal mode recovery, button edge, tick.
   always_comb begin
      mode_d   = mode_q;
      led_d    = led_q;
      cnt_d    = cnt_q;
      dir_up_d = dir_up_q;
      tick_d   = 1'b0;
      btn_d    = i_btn;

      if (!mode_legal) begin
         mode_d   = MODE_CHASE;
         led_d    = 5'b00001;
         cnt_d    = '0;
         dir_up_d = 1'b1;
      end else if (btn_rise) begin
         // A mode change restarts the divider even while paused, and
         // swallows a coincident terminal count.
         mode_d   = mode_next;
         led_d    = init_led;
         cnt_d    = '0;
         dir_up_d = 1'b1;
      end else if (!i_pause) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d    = '0;
            tick_d   = 1'b1;
            led_d    = step_led;
            dir_up_d = step_dir_up;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         mode_q   <= MODE_CHASE;
         led_q    <= 5'b00001;
         cnt_q    <= '0;
         dir_up_q <= 1'b1;
         tick_q   <= 1'b0;
         // Loading the live level means a button held through reset does
         // not register as a press once reset is released.
         btn_q    <= i_btn;
      end else begin
         mode_q   <= mode_d;
         led_q    <= led_d;
         cnt_q    <= cnt_d;
         dir_up_q <= dir_up_d;
         tick_q   <= tick_d;
         btn_q    <= btn_d;
      end
   end

   assign o_led  = led_q;
   assign o_mode = mode_q;
   assign o_tick = tick_q;

endmodule

// File: doc/led_pattern_scheduler.md
Name: led_pattern_scheduler

Overview:
- Sequencing controller for the 5-LED front-panel bank.
- Selects one of five display modes from a debounced push-button. Each button press advances to the next mode.
- Runs a programmable tick divider and steps the LED pattern of the active mode once per tick.
- Sits between the button debouncer and the board LED pins, in place of the free-running sequential blinker.

Parameters:
- TICK_DIV, 6250000, clock cycles per pattern step (must be ≥ 2); benches use 4.
- CNT_W, 23, tick counter width (must hold TICK_DIV-1).

Ports:
- i_clk  in  1  system clock; one clock domain only.
- i_rst  in  1  synchronous, active-high reset.
- i_btn  in  1  debounced button level, synchronous to i_clk; a rising edge advances the mode.
- i_pause  in  1  level; while high, pattern stepping is frozen.
- o_led  out  5  LED drive, bit0 = o_led1 … bit4 = o_led5; registered.
- o_mode  out  3  current mode code; registered.
- o_tick  out  1  one-cycle pulse, high in the same cycle a new stepped pattern first appears on o_led.

Behaviour:
- Reset (i_rst high at a clock edge):
  - mode=CHASE(0), o_led=5'b00001, tick counter=0, bounce direction=up, o_tick=0.
  - Button history register loads i_btn, so a button held through reset causes no mode change on release of reset.
  - Reset mid-pattern or mid-count takes effect at the next edge and overrides all other events.
- Modes and codes: CHASE=0, BOUNCE=1, BLINK=2, COUNT=3, OFF=4. Codes 5–7 are unreachable; if ever entered, go to CHASE at the next edge.
- Mode advance:
  - Rising edge is i_btn=1 with history=0. History register updates every cycle.
  - Order: 0→1→2→3→4→0.
  - At the detecting edge: mode←next, o_led←initial pattern of the new mode, counter←0, o_tick←0, direction←up.
  - Latency: new mode and pattern are visible one cycle after i_btn rises.
- Initial patterns: CHASE 00001, BOUNCE 00001, BLINK 00000, COUNT 00000, OFF 00000.
- Tick divider:
  - Counter increments each cycle while i_pause=0.
  - When counter==TICK_DIV-1: counter←0, o_tick←1, o_led←step(mode). Otherwise o_tick←0.
  - Tick period is exactly TICK_DIV cycles.
- Step rules (applied on each tick):
  - CHASE: rotate left 5 bits; 10000→00001.
  - BOUNCE: shift left while direction=up. On reaching 10000, direction←down; then shift right. On reaching 00001, direction←up. Sequence: 1,2,4,8,16,8,4,2,1,2,…
  - BLINK: o_led←~o_led (00000↔11111).
  - COUNT: o_led←o_led+1, mod 32; 11111→00000 with no carry out.
  - OFF: o_led stays 00000; o_tick still pulses.
- Pause:
  - Counter holds its value and o_tick stays 0.
  - Button edges are still honoured. A mode change during pause resets the counter to 0.
  - On release, counting resumes from the held value.
- Simultaneous events:
  - Button edge in the same cycle as a terminal count: mode change wins, no step is applied, o_tick=0.
  - Reset beats everything.

Test Plan (TICK_DIV=4):
- Reset then run 20 cycles → o_mode=0; o_led 00001, 00010, 00100, 01000, 10000, 00001; one step every 4 cycles; o_tick high exactly on the change cycles.
- Press once, run 40 cycles → o_mode=1; o_led sequence 1,2,4,8,16,8,4,2,1,2 (decimal), each held 4 cycles.
- Press to COUNT (3 presses from reset), run 33 ticks → o_led counts 0..31, wraps to 0, then 1.
- Hold i_pause for 10 cycles mid-CHASE at counter=2 → o_led and o_tick frozen; after release, the next step occurs 2 cycles later (counter 2→3 then wrap).
- Assert button rising edge on the terminal-count cycle in BLINK → next cycle o_mode=3, o_led=00000, o_tick=0; first COUNT step 4 cycles later.
- Assert i_rst for 1 cycle while in BOUNCE going down with i_btn held high → o_mode=0, o_led=00001; no mode advance after reset even though i_btn stays high.
